// File: rtl/clk_div_pkg.sv
// Shared types and constants for the divider ratio control stage.
package clk_div_pkg;

  localparam int RATIO_W = 4;
  localparam logic [RATIO_W-1:0] MIN_RATIO = 4'd2;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    WAIT_LOW = 3'd1,
    GATE     = 3'd2,
    LOCKING  = 3'd3,
    LOCKED   = 3'd4
  } state_t;

  // A request is unusable only when it asks to run at a ratio the divider cannot produce.
  function automatic logic req_is_bad(input logic en, input logic [RATIO_W-1:0] ratio);
    return en && (ratio < MIN_RATIO);
  endfunction

endpackage

// File: rtl/clk_div_ratio_ctrl.sv
// Ratio/enable control stage in front of the integer clock divider.
// Ratio changes are applied only while the divided clock is low, followed by a
// forced gate interval, so the divided clock never shows a runt pulse.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// OFF      | divider stopped; ratio may be updated freely
// WAIT_LOW | change pending; waiting for divided clock low to stop divider
// GATE     | divider held off for GATE_CYCLES with the new ratio applied
// LOCKING  | divider enabled; waiting for the first rising edge (timed)
// LOCKED   | divider running at o_div_ratio
module clk_div_ratio_ctrl
  import clk_div_pkg::*;
#(
  parameter logic [RATIO_W-1:0] DEFAULT_RATIO = 4'd8,
  parameter int                 GATE_CYCLES   = 2,
  parameter bit                 AUTO_START    = 1'b1,
  parameter int                 LOCK_TIMEOUT  = 64
) (
  input  logic               i_ref_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  input  logic [RATIO_W-1:0] i_req_ratio,
  input  logic               i_req_en,
  output logic               o_req_ready,
  input  logic               i_div_clk,
  output logic [RATIO_W-1:0] o_div_ratio,
  output logic               o_clk_en,
  output logic               o_locked,
  output logic               o_err_invalid,
  output logic               o_err_timeout
);

  localparam int TO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LOAD   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]      GATE_LOAD = 4'(GATE_CYCLES - 1);

  state_t             state, state_nxt;
  logic               div_q;
  logic               rise;
  logic               auto_pend, auto_nxt;
  logic [RATIO_W-1:0] pend_ratio, pend_ratio_nxt;
  logic               pend_en, pend_en_nxt;
  logic [3:0]         gate_cnt, gate_cnt_nxt;
  logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
  logic [RATIO_W-1:0] ratio_nxt;
  logic               clk_en_nxt, locked_nxt, err_inv_nxt, err_to_nxt;
  logic               accept, req_bad, accept_ok;

  assign o_req_ready = (state == OFF) || (state == LOCKED);
  assign rise        = i_div_clk & ~div_q;
  assign accept      = i_req_valid & o_req_ready;
  assign req_bad     = req_is_bad(i_req_en, i_req_ratio);
  assign accept_ok   = accept & ~req_bad;

  // Register state, timers, pending request and all outputs.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= OFF;
      div_q         <= 1'b0;
      auto_pend     <= AUTO_START;
      pend_ratio    <= DEFAULT_RATIO;
      pend_en       <= 1'b0;
      gate_cnt      <= GATE_LOAD;
      to_cnt        <= TO_LOAD;
      o_div_ratio   <= DEFAULT_RATIO;
      o_clk_en      <= 1'b0;
      o_locked      <= 1'b0;
      o_err_invalid <= 1'b0;
      o_err_timeout <= 1'b0;
    end else begin
      state         <= state_nxt;
      div_q         <= i_div_clk;
      auto_pend     <= auto_nxt;
      pend_ratio    <= pend_ratio_nxt;
      pend_en       <= pend_en_nxt;
      gate_cnt      <= gate_cnt_nxt;
      to_cnt        <= to_cnt_nxt;
      o_div_ratio   <= ratio_nxt;
      o_clk_en      <= clk_en_nxt;
      o_locked      <= locked_nxt;
      o_err_invalid <= err_inv_nxt;
      o_err_timeout <= err_to_nxt;
    end
  end

  // Next-state and next-output decode; timers reload whenever their state is not active.
  always_comb begin
    state_nxt      = state;
    auto_nxt       = auto_pend;
    pend_ratio_nxt = pend_ratio;
    pend_en_nxt    = pend_en;
    gate_cnt_nxt   = GATE_LOAD;
    to_cnt_nxt     = TO_LOAD;
    ratio_nxt      = o_div_ratio;
    clk_en_nxt     = o_clk_en;
    locked_nxt     = o_locked;
    err_inv_nxt    = 1'b0;
    err_to_nxt     = o_err_timeout;

    if (accept && req_bad) begin
      err_inv_nxt = 1'b1;
    end else if (accept) begin
      pend_ratio_nxt = i_req_ratio;
      pend_en_nxt    = i_req_en;
      locked_nxt     = 1'b0;
      if (i_req_en) err_to_nxt = 1'b0;
    end

    case (state)
      OFF: begin
        auto_nxt = 1'b0;
        if (accept_ok) begin
          ratio_nxt = i_req_ratio;
          if (i_req_en) state_nxt = GATE;
        end else if (auto_pend) begin
          state_nxt  = LOCKING;
          clk_en_nxt = 1'b1;
          ratio_nxt  = DEFAULT_RATIO;
        end
      end
      WAIT_LOW: begin
        // Stopping the divider while its output is low avoids truncating a high phase.
        if (!i_div_clk) begin
          state_nxt  = GATE;
          clk_en_nxt = 1'b0;
          ratio_nxt  = pend_ratio;
        end
      end
      GATE: begin
        if (gate_cnt == 4'd0) begin
          state_nxt  = pend_en ? LOCKING : OFF;
          clk_en_nxt = pend_en;
        end else begin
          gate_cnt_nxt = gate_cnt - 4'd1;
        end
      end
      LOCKING: begin
        if (rise) begin
          state_nxt  = LOCKED;
          locked_nxt = 1'b1;
        end else if (to_cnt == '0) begin
          state_nxt  = OFF;
          clk_en_nxt = 1'b0;
          err_to_nxt = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt - 1'b1;
        end
      end
      LOCKED: begin
        if (accept_ok) state_nxt = WAIT_LOW;
      end
      default: begin
        state_nxt  = OFF;
        clk_en_nxt = 1'b0;
      end
    endcase

    if (state_nxt != LOCKED) locked_nxt = 1'b0;
  end

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Directed bench: ratio control closed-loop with a behavioural integer divider.
module tb_clk_div_ratio_ctrl;
  import clk_div_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic [RATIO_W-1:0] req_ratio;
  logic               req_en;
  logic               req_ready;
  logic [RATIO_W-1:0] div_ratio;
  logic               clk_en;
  logic               locked;
  logic               err_invalid;
  logic               err_timeout;
  logic               div_fb;
  logic               disconnect;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clk_div_ratio_ctrl dut (
    .i_ref_clk     (clk),
    .i_rst_n       (rst_n),
    .i_req_valid   (req_valid),
    .i_req_ratio   (req_ratio),
    .i_req_en      (req_en),
    .o_req_ready   (req_ready),
    .i_div_clk     (div_fb),
    .o_div_ratio   (div_ratio),
    .o_clk_en      (clk_en),
    .o_locked      (locked),
    .o_err_invalid (err_invalid),
    .o_err_timeout (err_timeout)
  );

  // Behavioural divider: count resets while disabled, output high for ratio/2 counts.
  logic [3:0] dcnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    dcnt <= 4'd0;
    else if (!clk_en)              dcnt <= 4'd0;
    else if (dcnt >= div_ratio - 4'd1) dcnt <= 4'd0;
    else                           dcnt <= dcnt + 4'd1;
  end
  assign div_fb = disconnect ? 1'b0 : (clk_en && (dcnt < (div_ratio >> 1)));

  // Monitors: short high pulses on the divided clock, and ratio changes while enabled.
  int hi_run = 0, runt_cnt = 0, inv_err = 0;
  logic prev_en = 1'b0;
  logic [3:0] prev_ratio = 4'd0;
  always @(negedge clk) begin
    if (div_fb) hi_run++;
    else begin
      if (hi_run > 0 && hi_run < 2) runt_cnt++;
      hi_run = 0;
    end
    if (prev_en && clk_en && (div_ratio != prev_ratio)) inv_err++;
    prev_en    = clk_en;
    prev_ratio = div_ratio;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic measure(output int hi, output int lo);
    int g;
    hi = 0; lo = 0; g = 0;
    while (div_fb && g < 100)  begin @(negedge clk); g++; end
    while (!div_fb && g < 100) begin @(negedge clk); g++; end
    while (div_fb && g < 100)  begin @(negedge clk); hi++; g++; end
    while (!div_fb && g < 100) begin @(negedge clk); lo++; g++; end
  endtask

  task automatic wait_locked(input string tag, input int limit);
    int n;
    n = 0;
    while (!locked && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_seen"}, locked, 1);
    chk({tag, "_within"}, (n <= limit), 1);
  endtask

  task automatic send(input logic [3:0] r, input logic e);
    req_valid = 1'b1; req_ratio = r; req_en = e;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int hi, lo, g, n;
    logic prev_div;
    rst_n = 1'b0; req_valid = 1'b0; req_ratio = 4'd0; req_en = 1'b0; disconnect = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk_en", clk_en, 0);
    chk("rst_ratio", div_ratio, 8);
    chk("rst_locked", locked, 0);
    chk("rst_err_inv", err_invalid, 0);
    chk("rst_err_to", err_timeout, 0);
    chk("rst_ready", req_ready, 1);

    // Auto-start at ratio 8.
    rst_n = 1'b1;
    @(negedge clk);
    chk("auto_clk_en", clk_en, 1);
    chk("auto_ratio", div_ratio, 8);
    chk("auto_ready", req_ready, 0);
    wait_locked("lock8", 9);
    measure(hi, lo);
    chk("p8_high", hi, 4);
    chk("p8_period", hi + lo, 8);

    // Switch 8 -> 5.
    send(4'd5, 1'b1);
    chk("sw5_ready", req_ready, 0);
    chk("sw5_locked_clr", locked, 0);
    chk("sw5_en_held", clk_en, 1);
    prev_div = div_fb; g = 0;
    while (clk_en && g < 40) begin prev_div = div_fb; @(negedge clk); g++; end
    chk("sw5_stop_on_low", prev_div, 0);
    chk("sw5_ratio", div_ratio, 5);
    n = 0;
    while (!clk_en && n < 40) begin n++; @(negedge clk); end
    chk("sw5_gate_len", n, 2);
    wait_locked("lock5", 3);
    measure(hi, lo);
    chk("p5_high", hi, 2);
    chk("p5_low", lo, 3);

    // Invalid ratio is rejected without disturbing anything.
    send(4'd1, 1'b1);
    chk("inv_pulse", err_invalid, 1);
    chk("inv_ratio", div_ratio, 5);
    chk("inv_clk_en", clk_en, 1);
    chk("inv_locked", locked, 1);
    @(negedge clk);
    chk("inv_pulse_end", err_invalid, 0);

    // Stop with ratio 12, then restart at 12 from OFF.
    send(4'd12, 1'b0);
    g = 0;
    while (clk_en && g < 40) begin @(negedge clk); g++; end
    repeat (5) @(negedge clk);
    chk("stop_clk_en", clk_en, 0);
    chk("stop_div", div_fb, 0);
    chk("stop_ratio", div_ratio, 12);
    chk("stop_ready", req_ready, 1);
    chk("stop_locked", locked, 0);
    send(4'd12, 1'b1);
    chk("st12_gate1_en", clk_en, 0);
    chk("st12_gate1_rdy", req_ready, 0);
    @(negedge clk);
    chk("st12_gate2_en", clk_en, 0);
    @(negedge clk);
    chk("st12_locking_en", clk_en, 1);
    wait_locked("lock12", 3);
    measure(hi, lo);
    chk("p12_period", hi + lo, 12);

    // Lock timeout with the feedback held low.
    g = 0;
    while (div_fb && g < 20) begin @(negedge clk); g++; end
    disconnect = 1'b1;
    send(4'd12, 1'b1);
    g = 0;
    while (clk_en && g < 40) begin @(negedge clk); g++; end
    g = 0;
    while (!clk_en && g < 40) begin @(negedge clk); g++; end
    n = 0;
    while (clk_en && n < 200) begin n++; @(negedge clk); end
    chk("to_cycles", n, 64);
    chk("to_err", err_timeout, 1);
    chk("to_clk_en", clk_en, 0);
    chk("to_ready", req_ready, 1);
    disconnect = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_sticky", err_timeout, 1);

    // Request from OFF clears the timeout; reset while in GATE.
    send(4'd6, 1'b1);
    chk("to_clear", err_timeout, 0);
    chk("gate_ratio6", div_ratio, 6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clk_en", clk_en, 0);
    chk("mid_rst_ratio", div_ratio, 8);
    chk("mid_rst_locked", locked, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rearm_clk_en", clk_en, 1);
    chk("rearm_ratio", div_ratio, 8);
    wait_locked("relock8", 9);
    measure(hi, lo);
    chk("rearm_period", hi + lo, 8);

    chk("no_runt_pulses", runt_cnt, 0);
    chk("ratio_stable_while_en", inv_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
